// File: rtl/baud_rate_gen.sv
// Serial baud-rate generator: oversample strobe, bit strobe and bit-rate square wave for TX/RX.
// All outputs registered; first os tick P clocks after counter zero; no backpressure, free-running.
module baud_rate_gen #(
  parameter int DIV_W     = 16,
  parameter int OVS       = 16,
  parameter int OVS_W     = 4,
  parameter int MODE0_DIV = 12
) (
  input  logic             system_clk_i,
  input  logic             system_rst_i,
  input  logic             baud_rate_en_i,
  input  logic [1:0]       baud_rate_mode_i,
  input  logic             baud_rate_smod_i,
  input  logic [DIV_W-1:0] baud_rate_div_i,
  input  logic             baud_rate_div_wr_i,
  input  logic             baud_rate_clear_i,
  output logic             baud_rate_os_tick_o,
  output logic             baud_rate_br_tick_o,
  output logic             baud_rate_br_o,
  output logic             baud_rate_div_busy_o
);

  localparam int CNT_W = DIV_W + 1;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE2 = 2'b10;

  localparam logic [CNT_W-1:0] M0_TERM   = CNT_W'(MODE0_DIV - 1);
  localparam logic [CNT_W-1:0] M0_HALF   = CNT_W'(MODE0_DIV / 2);
  localparam logic [CNT_W-1:0] M2_TERM_N = CNT_W'(64 / OVS - 1);
  localparam logic [CNT_W-1:0] M2_TERM_D = CNT_W'(32 / OVS - 1);
  localparam logic [OVS_W-1:0] OS_LAST   = OVS_W'(OVS - 1);

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [OVS_W-1:0] os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [DIV_W-1:0] pending_div_q, pending_div_d;
  logic             busy_q, busy_d;
  logic             os_tick_q, br_tick_q, br_q, br_d;

  logic [CNT_W-1:0] term_val;
  logic             run, at_term, os_hit, bit_hit, apply;

  // Terminal count is P-1; for the variable modes 2*(div+1)-1 = {div,1} stays within CNT_W bits.
  always_comb begin
    term_val = M0_TERM;
    unique case (baud_rate_mode_i)
      MODE0:   term_val = M0_TERM;
      MODE2:   term_val = baud_rate_smod_i ? M2_TERM_D : M2_TERM_N;
      default: term_val = baud_rate_smod_i ? {1'b0, active_div_q} : {active_div_q, 1'b1};
    endcase
  end

  assign run     = baud_rate_en_i && !baud_rate_clear_i;
  assign at_term = (pre_cnt_q == term_val);
  assign os_hit  = run && at_term;
  assign bit_hit = os_hit && ((baud_rate_mode_i == MODE0) || (os_cnt_q == OS_LAST));
  assign apply   = bit_hit || !run;

  // A counter left above a shrunken terminal simply rolls over at all-ones.
  always_comb begin
    pre_cnt_d = pre_cnt_q + CNT_W'(1);
    if (!run || at_term) begin
      pre_cnt_d = '0;
    end
  end

  always_comb begin
    os_cnt_d = os_cnt_q;
    if (!run || (baud_rate_mode_i == MODE0)) begin
      os_cnt_d = '0;
    end else if (os_hit) begin
      os_cnt_d = os_cnt_q + OVS_W'(1);
    end
  end

  // Square wave is registered from next-state so its edges line up with the tick strobes.
  always_comb begin
    if (baud_rate_mode_i == MODE0) begin
      br_d = (pre_cnt_d >= M0_HALF);
    end else begin
      br_d = os_cnt_d[OVS_W-1];
    end
  end

  always_comb begin
    active_div_d  = active_div_q;
    pending_div_d = pending_div_q;
    busy_d        = busy_q;
    if (baud_rate_div_wr_i) begin
      pending_div_d = baud_rate_div_i;
      if (apply) begin
        active_div_d = baud_rate_div_i;
        busy_d       = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (apply) begin
      active_div_d = pending_div_q;
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge system_clk_i or posedge system_rst_i) begin
    if (system_rst_i) begin
      pre_cnt_q     <= '0;
      os_cnt_q      <= '0;
      active_div_q  <= '0;
      pending_div_q <= '0;
      busy_q        <= 1'b0;
      os_tick_q     <= 1'b0;
      br_tick_q     <= 1'b0;
      br_q          <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      os_cnt_q      <= os_cnt_d;
      active_div_q  <= active_div_d;
      pending_div_q <= pending_div_d;
      busy_q        <= busy_d;
      os_tick_q     <= os_hit;
      br_tick_q     <= bit_hit;
      br_q          <= br_d;
    end
  end

  assign baud_rate_os_tick_o  = os_tick_q;
  assign baud_rate_br_tick_o  = br_tick_q;
  assign baud_rate_br_o       = br_q;
  assign baud_rate_div_busy_o = busy_q;

endmodule

// File: doc/baud_rate_gen.md
Name: baud_rate_gen

Overview:
- Parametrised successor to the fixed-ratio serial baud-rate generator.
- Produces three outputs for the serial TX/RX engines: a one-clock oversample strobe for RX sampling, a one-clock bit strobe, and a 50%-duty bit-rate square wave.
- Supports four 8051-style serial modes with a programmable, double-buffered divisor for the variable-rate modes, plus a synchronous phase-clear used by RX on start-bit detection.

Parameters:
- DIV_W, 16: width of the programmable divisor.
- OVS, 16: oversample factor (bit period = OVS oversample ticks); power of two, 2..32.
- OVS_W, 4: log2(OVS).
- MODE0_DIV, 12: system clocks per bit in mode 0; at least 2.

Ports:
- system_clk_i  in  1  system clock; all logic on rising edge.
- system_rst_i  in  1  asynchronous, active-high reset.
- baud_rate_en_i  in  1  generator enable.
- baud_rate_mode_i  in  2  00 = mode0 fixed, 01 = mode1 variable, 10 = mode2 fixed, 11 = mode3 variable.
- baud_rate_smod_i  in  1  rate doubler.
- baud_rate_div_i  in  DIV_W  divisor write data.
- baud_rate_div_wr_i  in  1  one-clock strobe that loads div_i into the pending register.
- baud_rate_clear_i  in  1  synchronous phase resync.
- baud_rate_os_tick_o  out  1  oversample strobe.
- baud_rate_br_tick_o  out  1  bit strobe.
- baud_rate_br_o  out  1  bit-rate square wave.
- baud_rate_div_busy_o  out  1  pending divisor not yet applied.

Behaviour:
- Reset (async, active-high):
  - pre_cnt, os_cnt, active_div and pending_div go to 0; busy goes to 0.
  - All outputs go to 0 immediately, without waiting for a clock edge.
- Prescale period P:
  - mode 00: P = MODE0_DIV.
  - mode 10: P = 64/OVS when smod = 0, 32/OVS when smod = 1.
  - modes 01/11: P = 2*(active_div+1) when smod = 0, (active_div+1) when smod = 1.
  - The pre_cnt register is DIV_W+1 bits wide. active_div = 0 with smod = 1 gives P = 1, i.e. an oversample tick every clock.
- Prescaler:
  - pre_cnt counts up from 0. At P-1 it returns to 0 and raises internal os_hit.
- Oversample counter:
  - os_cnt (OVS_W bits) increments on os_hit and wraps from OVS-1 to 0.
  - bit_hit = os_hit AND os_cnt == OVS-1.
  - In mode 00 os_cnt is held at 0 and bit_hit = os_hit.
- Tick outputs:
  - os_tick_o and br_tick_o are registered copies of os_hit and bit_hit, each high for exactly one clock.
  - Latency: the first os_tick comes exactly P clocks after the counter-zero point; subsequent os_ticks every P clocks.
  - Modes 01/10/11: br_tick every OVS*P clocks. Mode 00: br_tick every MODE0_DIV clocks.
- br_o (registered):
  - Modes 01/10/11: equals os_cnt[OVS_W-1], i.e. low for the first OVS/2 oversample periods of a bit, high for the second half.
  - Mode 00: high while pre_cnt >= MODE0_DIV/2.
- Divisor double-buffer:
  - div_wr loads pending_div and sets busy.
  - Pending is copied to active_div, and busy cleared, at the next apply point: the clock where bit_hit fires, clear_i is high, or en_i is low.
  - If div_wr coincides with an apply point, the newly written value is applied directly and busy stays 0.
  - Back-to-back writes before apply: the last write wins.
- Mode and smod changes:
  - These are not buffered; P is re-evaluated every cycle. Software issues clear after changing mode or smod.
  - If a change shrinks P below the current pre_cnt, the counter also wraps at its maximum (all ones) and continues without a tick.
- clear_i:
  - pre_cnt and os_cnt go to 0. os_hit and bit_hit are suppressed in that cycle, even if a terminal count coincides.
  - br_o goes to 0 next clock.
  - Clear has priority over enable and over counting.
- Enable low:
  - Counters held at 0, no ticks, br_o = 0, pending divisor still applied.
  - When en rises, the first os_tick comes P clocks later.
- Reset mid-bit: everything returns to reset values asynchronously. After release, the generator restarts from count 0 with active_div = 0 (divisor must be rewritten).

Test Plan:
- Reset check: assert reset mid-bit → all outputs 0 in the same cycle. Release with mode 10, smod 0, en 1 → first os_tick 4 clocks later.
- Mode 10, OVS 16:
  - smod 0 → os_tick every 4 clocks; br_tick every 64 clocks; br_o low 32 / high 32.
  - smod 1 → os_tick every 2 clocks, br_tick every 32 clocks.
- Mode 01, div 5:
  - smod 1 → os_tick every 6 clocks, br_tick every 96 clocks.
  - smod 0 → os_tick every 12 clocks, br_tick every 192 clocks.
- Divisor change: mode 11, smod 1, div 5; write div 2 at os_cnt 7 →
  - busy high until br_tick;
  - following bit has os_tick every 3 clocks, br_tick 48 clocks later;
  - a write coincident with br_tick leaves busy 0.
- Clear: pulse clear at pre_cnt 3 of P 6 → no tick that cycle; next os_tick exactly 6 clocks later; br_tick 96 clocks later. Clear coincident with terminal count → tick suppressed.
- Mode 00, MODE0_DIV 12:
  - br_tick = os_tick every 12 clocks; br_o high 6 / low 6.
  - en low for 20 clocks → no ticks, br_o 0; en high → first tick 12 clocks later.
